// File: rtl/tlb_op_sched_if.sv
// ---------------------------------------------------------------------------
// tlb_op_sched_if
// Bundles every handshake and bus signal of the TLB maintenance scheduler so
// the scheduler and its environment can be connected through one port.
//
// Groups:
//   p_*      pipeline request  (valid/ready, op, addr, data, tag)
//   d_*      loader request    (valid/ready, op, addr, data)
//   rsp_*    response          (valid/ready, src, op, data, tag)
//   tlb_*    TLB control port  (read_addr, we, invalidate, clear,
//                               write_data, read_addr_out)
//   busy     scheduler is not idle
//
// Modports:
//   slave    scheduler view (tlb_op_sched)
//   master   environment view (requesters, response consumer, TLB)
// ---------------------------------------------------------------------------
interface tlb_op_sched_if #(
  parameter int TAG_W = 4,
  parameter int VAL_W = 27
);

  logic             p_valid;
  logic             p_ready;
  logic [1:0]       p_op;
  logic [31:0]      p_addr;
  logic [31:0]      p_data;
  logic [TAG_W-1:0] p_tag;

  logic             d_valid;
  logic             d_ready;
  logic [1:0]       d_op;
  logic [31:0]      d_addr;
  logic [31:0]      d_data;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_src;
  logic [1:0]       rsp_op;
  logic [VAL_W-1:0] rsp_data;
  logic [TAG_W-1:0] rsp_tag;

  logic [31:0]      tlb_read_addr;
  logic             tlb_we;
  logic             tlb_invalidate;
  logic             tlb_clear;
  logic [31:0]      tlb_write_data;
  logic [VAL_W-1:0] tlb_read_addr_out;

  logic             busy;

  modport slave (
    input  p_valid, p_op, p_addr, p_data, p_tag,
    output p_ready,
    input  d_valid, d_op, d_addr, d_data,
    output d_ready,
    output rsp_valid, rsp_src, rsp_op, rsp_data, rsp_tag,
    input  rsp_ready,
    output tlb_read_addr, tlb_we, tlb_invalidate, tlb_clear, tlb_write_data,
    input  tlb_read_addr_out,
    output busy
  );

  modport master (
    output p_valid, p_op, p_addr, p_data, p_tag,
    input  p_ready,
    output d_valid, d_op, d_addr, d_data,
    input  d_ready,
    input  rsp_valid, rsp_src, rsp_op, rsp_data, rsp_tag,
    output rsp_ready,
    input  tlb_read_addr, tlb_we, tlb_invalidate, tlb_clear, tlb_write_data,
    output tlb_read_addr_out,
    input  busy
  );

endinterface

// File: rtl/tlb_op_sched.sv
// ---------------------------------------------------------------------------
// tlb_op_sched
// Serializes TLB maintenance operations (read / write / invalidate / clear)
// from the pipeline and from the boot/debug loader onto the single TLB
// control port. Exactly one operation is in flight; each one is answered by
// a single response beat.
//
// Sequence per operation: IDLE -> ISSUE -> (WAIT for reads) -> RESP -> IDLE.
// Grant-to-response latency is 2 enabled cycles for write/invalidate/clear
// and 3 for reads.
//
// Ports:
//   clk      clock
//   rst_n    synchronous active-low reset (takes effect regardless of clk_en)
//   clk_en   global stall; no state moves while it is 0
//   bus      tlb_op_sched_if.slave: pipeline/loader requests, response,
//            TLB control port and busy flag
//
// Configuration macro:
//   TLB_LOADER_PORT_EN  when defined the loader port takes part in
//                       round-robin arbitration with the pipeline; when not
//                       defined d_ready is 0, d_* are ignored and rsp_src is
//                       always 0.
// ---------------------------------------------------------------------------
module tlb_op_sched #(
  parameter int TAG_W = 4,
  parameter int VAL_W = 27
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clk_en,
  tlb_op_sched_if.slave bus
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_INVAL = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [1:0]       op_q;
  logic [31:0]      addr_q;
  logic [31:0]      data_q;
  logic [TAG_W-1:0] tag_q;
  logic             src_q;
  logic [VAL_W-1:0] rsp_data_q;

  // Last granted source: 0 pipeline, 1 loader. Reset value 1 hands the
  // first contested grant to the pipeline.
  logic             rr_last_q;

  logic             grant_p;
  logic             grant_d;
  logic             take;

  // Arbitration between the two requesters, independent of state/clk_en;
  // those qualifiers are applied when forming the ready outputs.
`ifdef TLB_LOADER_PORT_EN
  always_comb begin
    grant_p = bus.p_valid && (!bus.d_valid || rr_last_q);
    grant_d = bus.d_valid && (!bus.p_valid || !rr_last_q);
  end
`else
  logic unused_loader;

  always_comb begin
    grant_p = bus.p_valid;
    grant_d = 1'b0;
  end

  assign unused_loader = ^{bus.d_valid, bus.d_op, bus.d_addr, bus.d_data, rr_last_q};
`endif

  // A grant can only happen from IDLE on an enabled cycle; this is also
  // what keeps a new grant out of the cycle in which a response is accepted.
  assign take        = clk_en && (state_q == IDLE);
  assign bus.p_ready = grant_p && take;
  assign bus.d_ready = grant_d && take;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else if (clk_en) begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Every transition also waits for clk_en, so a stall
  // in any state freezes the whole sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (clk_en && (grant_p || grant_d)) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (clk_en) begin
          state_d = (op_q == OP_READ) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (clk_en) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (clk_en && bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request capture at grant and read-result capture at the end of WAIT.
  // rsp_data is cleared at grant so non-read ops and misses answer 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q       <= 2'b00;
      addr_q     <= 32'h0;
      data_q     <= 32'h0;
      tag_q      <= '0;
      src_q      <= 1'b0;
      rsp_data_q <= '0;
      rr_last_q  <= 1'b1;
    end else if (clk_en) begin
      if (state_q == IDLE) begin
        if (grant_p) begin
          op_q       <= bus.p_op;
          addr_q     <= bus.p_addr;
          data_q     <= bus.p_data;
          tag_q      <= bus.p_tag;
          src_q      <= 1'b0;
          rsp_data_q <= '0;
          rr_last_q  <= 1'b0;
        end else if (grant_d) begin
          op_q       <= bus.d_op;
          addr_q     <= bus.d_addr;
          data_q     <= bus.d_data;
          tag_q      <= '0;
          src_q      <= 1'b1;
          rsp_data_q <= '0;
          rr_last_q  <= 1'b1;
        end
      end
      if (state_q == WAIT) begin
        rsp_data_q <= bus.tlb_read_addr_out;
      end
    end
  end

  // TLB control port. The lookup key comes straight from the captured
  // address, so it holds its last value outside ISSUE/WAIT. Strobes decode
  // from the one-cycle ISSUE state, which makes them mutually exclusive.
  assign bus.tlb_read_addr  = addr_q;
  assign bus.tlb_write_data = data_q;
  assign bus.tlb_we         = (state_q == ISSUE) && (op_q == OP_WRITE);
  assign bus.tlb_invalidate = (state_q == ISSUE) && (op_q == OP_INVAL);
  assign bus.tlb_clear      = (state_q == ISSUE) && (op_q == OP_CLEAR);

  // Response beat, held stable for the whole of RESP.
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_src   = src_q;
  assign bus.rsp_op    = op_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_tag   = tag_q;

  assign bus.busy = (state_q != IDLE);

endmodule

// File: tb/tb_tlb_op_sched.sv
// ---------------------------------------------------------------------------
// tb_tlb_op_sched
// Self-checking bench for tlb_op_sched. A small behavioural TLB answers the
// control port; expected responses come from a reference map of VPN -> value
// maintained from the operations the bench requests. Loader-specific steps
// follow the TLB_LOADER_PORT_EN macro.
// ---------------------------------------------------------------------------
module tb_tlb_op_sched;

  logic clk;
  logic rst_n;
  logic clk_en;

  int n_checks = 0;
  int n_fail   = 0;

  tlb_op_sched_if #(.TAG_W(4), .VAL_W(27)) bus ();

  tlb_op_sched #(.TAG_W(4), .VAL_W(27)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .bus    (bus)
  );

`ifdef TLB_LOADER_PORT_EN
  localparam bit LOADER_ON = 1'b1;
`else
  localparam bit LOADER_ON = 1'b0;
`endif

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a step never finishes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Behavioural TLB: applies strobes on enabled edges, registered lookup.
  logic [26:0] tlb_mem [logic [19:0]];

  always @(posedge clk) begin
    bus.tlb_read_addr_out <= tlb_mem.exists(bus.tlb_read_addr[31:12]) ?
                             tlb_mem[bus.tlb_read_addr[31:12]] : 27'h0;
    if (clk_en) begin
      if (bus.tlb_we) tlb_mem[bus.tlb_read_addr[31:12]] = bus.tlb_write_data[26:0];
      if (bus.tlb_invalidate && tlb_mem.exists(bus.tlb_read_addr[31:12]))
        tlb_mem.delete(bus.tlb_read_addr[31:12]);
      if (bus.tlb_clear) tlb_mem.delete();
    end
  end

  // Reference map of what the TLB should contain after each requested op.
  logic [26:0] ref_mem [logic [19:0]];

  function automatic logic [26:0] refRead(input logic [31:0] a);
    return ref_mem.exists(a[31:12]) ? ref_mem[a[31:12]] : 27'h0;
  endfunction

  task automatic refApply(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    case (op)
      2'b01: ref_mem[a[31:12]] = d[26:0];
      2'b10: if (ref_mem.exists(a[31:12])) ref_mem.delete(a[31:12]);
      2'b11: ref_mem.delete();
      default: ;
    endcase
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete operation from a single requester. hold = cycles with
  // rsp_ready low (pipeline valid raised meanwhile), stall = clk_en-low
  // cycles inserted during WAIT of a read.
  task automatic applyStimulus(input bit src, input logic [1:0] op, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] tag,
                               input int hold, input int stall);
    int          cyc;
    logic        rdy;
    logic [26:0] exp_val;
    exp_val = (op == 2'b00) ? refRead(addr) : 27'h0;
    @(negedge clk);
    if (!src) begin
      bus.p_valid = 1'b1; bus.p_op = op; bus.p_addr = addr; bus.p_data = data; bus.p_tag = tag;
    end else begin
      bus.d_valid = 1'b1; bus.d_op = op; bus.d_addr = addr; bus.d_data = data;
    end
    #1;
    cyc = 0;
    rdy = src ? bus.d_ready : bus.p_ready;
    while (!rdy && cyc < 10) begin
      @(negedge clk); #1;
      cyc++;
      rdy = src ? bus.d_ready : bus.p_ready;
    end
    checkOutput("grant_ready", rdy, 1);
    if (!rdy) begin
      bus.p_valid = 1'b0; bus.d_valid = 1'b0;
      return;
    end

    @(negedge clk);
    bus.p_valid = 1'b0; bus.d_valid = 1'b0;
    bus.p_op = 2'($urandom); bus.p_addr = $urandom; bus.p_data = $urandom;
    bus.d_op = 2'($urandom); bus.d_addr = $urandom; bus.d_data = $urandom;
    #1;
    checkOutput("issue_busy", bus.busy, 1);
    checkOutput("issue_addr", bus.tlb_read_addr, addr);
    checkOutput("issue_we", bus.tlb_we, op == 2'b01);
    checkOutput("issue_inval", bus.tlb_invalidate, op == 2'b10);
    checkOutput("issue_clear", bus.tlb_clear, op == 2'b11);
    checkOutput("issue_rsp_valid", bus.rsp_valid, 0);
    if (op == 2'b01) checkOutput("issue_wdata", bus.tlb_write_data, data);
    refApply(op, addr, data);

    if (op == 2'b00) begin
      @(negedge clk); #1;
      checkOutput("wait_strobes", {bus.tlb_we, bus.tlb_invalidate, bus.tlb_clear}, 3'b000);
      checkOutput("wait_addr", bus.tlb_read_addr, addr);
      checkOutput("wait_rsp_valid", bus.rsp_valid, 0);
      if (stall > 0) begin
        clk_en = 1'b0;
        repeat (stall) begin
          @(negedge clk); #1;
          checkOutput("stall_strobes", {bus.tlb_we, bus.tlb_invalidate, bus.tlb_clear}, 3'b000);
          checkOutput("stall_addr", bus.tlb_read_addr, addr);
          checkOutput("stall_rsp_valid", bus.rsp_valid, 0);
          checkOutput("stall_busy", bus.busy, 1);
        end
        clk_en = 1'b1;
      end
    end

    @(negedge clk); #1;
    checkOutput("rsp_valid", bus.rsp_valid, 1);
    checkOutput("rsp_op", bus.rsp_op, op);
    checkOutput("rsp_data", bus.rsp_data, exp_val);
    checkOutput("rsp_tag", bus.rsp_tag, src ? 4'h0 : tag);
    checkOutput("rsp_src", bus.rsp_src, src);

    if (hold > 0) begin
      bus.p_valid = 1'b1;
      repeat (hold) begin
        @(negedge clk); #1;
        checkOutput("hold_rsp_valid", bus.rsp_valid, 1);
        checkOutput("hold_rsp_data", bus.rsp_data, exp_val);
        checkOutput("hold_rsp_op", bus.rsp_op, op);
        checkOutput("hold_p_ready", bus.p_ready, 0);
      end
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk); #1;
    bus.rsp_ready = 1'b0;
    checkOutput("accept_rsp_valid", bus.rsp_valid, 0);
    checkOutput("accept_busy", bus.busy, 0);
    if (hold > 0) begin
      checkOutput("regrant_p_ready", bus.p_ready, 1);
      bus.p_valid = 1'b0;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  op;
    bit          src;

    rst_n = 1'b0; clk_en = 1'b1;
    bus.p_valid = 1'b0; bus.p_op = 2'b00; bus.p_addr = 32'h0; bus.p_data = 32'h0; bus.p_tag = 4'h0;
    bus.d_valid = 1'b0; bus.d_op = 2'b00; bus.d_addr = 32'h0; bus.d_data = 32'h0;
    bus.rsp_ready = 1'b0;
    $display("[TB] start, loader port enabled=%0d", LOADER_ON);

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_rsp_valid", bus.rsp_valid, 0);
    checkOutput("reset_strobes", {bus.tlb_we, bus.tlb_invalidate, bus.tlb_clear}, 3'b000);
    checkOutput("reset_read_addr", bus.tlb_read_addr, 32'h0);
    checkOutput("reset_wdata", bus.tlb_write_data, 32'h0);
    checkOutput("reset_rsp_data", bus.rsp_data, 27'h0);
    checkOutput("reset_rsp_tag", bus.rsp_tag, 4'h0);
    rst_n = 1'b1;

    // Stall gates the ready output.
    @(negedge clk);
    bus.p_valid = 1'b1; clk_en = 1'b0;
    #1;
    checkOutput("stalled_p_ready", bus.p_ready, 0);
    bus.p_valid = 1'b0;
    #1;
    clk_en = 1'b1;

    // Directed: write, read hit, read with stall, held response, miss, invalidate.
    applyStimulus(1'b0, 2'b01, 32'h0040_1000, 32'h0001_2007, 4'h5, 0, 0);
    applyStimulus(1'b0, 2'b00, 32'h0040_1000, 32'h0, 4'h9, 0, 0);
    applyStimulus(1'b0, 2'b00, 32'h0040_1abc, 32'h0, 4'h3, 0, 5);
    applyStimulus(1'b0, 2'b01, 32'h0040_2000, 32'hfabc_dead, 4'hc, 3, 0);
    applyStimulus(1'b0, 2'b00, 32'h0040_2000, 32'h0, 4'h1, 0, 0);
    applyStimulus(1'b0, 2'b00, 32'h0777_7000, 32'h0, 4'h2, 0, 0);
    applyStimulus(1'b0, 2'b10, 32'h0040_1000, 32'h0, 4'h4, 0, 0);
    applyStimulus(1'b0, 2'b00, 32'h0040_1000, 32'h0, 4'h6, 0, 0);

    // Randomized single-requester operations over a small VPN pool.
    for (int k = 0; k < 24; k++) begin
      a   = {20'h00400 + 20'($urandom_range(0, 3)), 12'($urandom)};
      op  = 2'($urandom_range(0, 3));
      src = LOADER_ON ? 1'($urandom_range(0, 1)) : 1'b0;
      applyStimulus(src, op, a, $urandom, 4'($urandom), $urandom_range(0, 2),
                    (op == 2'b00) ? $urandom_range(0, 2) : 0);
    end

`ifdef TLB_LOADER_PORT_EN
    // Both requesters valid from reset: grants alternate starting with the pipeline.
    begin
      bit          exp_p;
      bit          w_src;
      bit          last_src;
      logic [1:0]  w_op;
      logic [31:0] w_addr;
      logic [31:0] w_data;
      logic [3:0]  w_tag;
      logic [26:0] exp_val;
      int          cyc;
      doReset();
      last_src = 1'b1;
      bus.rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        bus.p_valid = 1'b1; bus.p_op = 2'($urandom_range(0, 2));
        bus.p_addr = {20'h00400 + 20'($urandom_range(0, 3)), 12'h0};
        bus.p_data = $urandom; bus.p_tag = 4'($urandom);
        bus.d_valid = 1'b1; bus.d_op = 2'($urandom_range(0, 2));
        bus.d_addr = {20'h00400 + 20'($urandom_range(0, 3)), 12'h0};
        bus.d_data = $urandom;
        #1;
        exp_p = last_src;
        checkOutput("rr_p_ready", bus.p_ready, exp_p);
        checkOutput("rr_d_ready", bus.d_ready, !exp_p);
        w_src  = !exp_p;
        w_op   = exp_p ? bus.p_op : bus.d_op;
        w_addr = exp_p ? bus.p_addr : bus.d_addr;
        w_data = exp_p ? bus.p_data : bus.d_data;
        w_tag  = exp_p ? bus.p_tag : 4'h0;
        exp_val = (w_op == 2'b00) ? refRead(w_addr) : 27'h0;
        refApply(w_op, w_addr, w_data);
        last_src = w_src;
        cyc = 0;
        do begin
          @(negedge clk); #1;
          cyc++;
        end while (!bus.rsp_valid && cyc < 6);
        checkOutput("rr_latency", cyc, (w_op == 2'b00) ? 3 : 2);
        checkOutput("rr_rsp_src", bus.rsp_src, w_src);
        checkOutput("rr_rsp_op", bus.rsp_op, w_op);
        checkOutput("rr_rsp_data", bus.rsp_data, exp_val);
        checkOutput("rr_rsp_tag", bus.rsp_tag, w_tag);
      end
      bus.p_valid = 1'b0; bus.d_valid = 1'b0;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
    end
`endif

    // Reset during the ISSUE cycle of a clear.
    @(negedge clk);
    bus.p_valid = 1'b1; bus.p_op = 2'b11; bus.p_addr = 32'h0040_3000; bus.p_tag = 4'h7;
`ifndef TLB_LOADER_PORT_EN
    bus.d_valid = 1'b1; bus.d_op = 2'b01; bus.d_addr = 32'h0040_3000; bus.d_data = 32'h1;
`endif
    #1;
    checkOutput("clr_p_ready", bus.p_ready, 1);
`ifndef TLB_LOADER_PORT_EN
    checkOutput("nold_d_ready_grant", bus.d_ready, 0);
`endif
    @(negedge clk);
    bus.p_valid = 1'b0;
    #1;
    checkOutput("clr_issue_strobe", bus.tlb_clear, 1);
`ifndef TLB_LOADER_PORT_EN
    checkOutput("nold_d_ready_issue", bus.d_ready, 0);
`endif
    rst_n = 1'b0;
    @(negedge clk); #1;
    checkOutput("rst_strobes", {bus.tlb_we, bus.tlb_invalidate, bus.tlb_clear}, 3'b000);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_rsp_valid", bus.rsp_valid, 0);
    checkOutput("rst_read_addr", bus.tlb_read_addr, 32'h0);
    rst_n = 1'b1;
`ifndef TLB_LOADER_PORT_EN
    @(negedge clk); #1;
    checkOutput("nold_d_ready_idle", bus.d_ready, 0);
    checkOutput("nold_busy_idle", bus.busy, 0);
    bus.d_valid = 1'b0;
`endif
    ref_mem.delete();
    applyStimulus(1'b0, 2'b11, 32'h0, 32'h0, 4'h8, 0, 0);
    applyStimulus(1'b0, 2'b00, 32'h0040_2000, 32'h0, 4'ha, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
